exe_mdu: RTL

Iterative multiply/divide unit in the EXE stage for the RV32M instructions. It consumes operands coming out of the ID/EXE pipeline register and pushes back the other way: it drives a stall that holds ID/EXE and the earlier stages while it iterates. When the result is ready it presents it with its destination register for one cycle so EXE can forward it to EXE/MEM.

---
 rtl/exe_mdu_pkg.sv | 35 +++
 rtl/exe_mdu_if.sv | 28 ++
 rtl/mdu_negate.sv | 10 +
 rtl/exe_mdu.sv | 122 ++++++++++++
 4 files changed

// File: rtl/exe_mdu_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package exe_mdu_pkg;

   localparam int unsigned GPR_WIDTH  = 32;
   localparam int unsigned GPR_ADDR_W = 5;

   // funct3 encodings of the M extension
   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

   // operand a is treated as signed
   function automatic logic op_signed_a(input mdu_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   // operand b is treated as signed
   function automatic logic op_signed_b(input mdu_op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/exe_mdu_if.sv
// Issue/result bundle between the EXE stage and the multiply/divide unit.
interface exe_mdu_if
   import exe_mdu_pkg::*;
#(
   parameter int unsigned XLEN   = GPR_WIDTH,
   parameter int unsigned ADDR_W = GPR_ADDR_W
);
   logic              start_i;
   logic [2:0]        op_i;
   logic [XLEN-1:0]   rs1_val_i;
   logic [XLEN-1:0]   rs2_val_i;
   logic [ADDR_W-1:0] rd_addr_i;
   logic              flush_i;
   logic              busy_o;
   logic              done_o;
   logic [XLEN-1:0]   result_o;
   logic [ADDR_W-1:0] rd_addr_o;

   modport slave (
      input  start_i, op_i, rs1_val_i, rs2_val_i, rd_addr_i, flush_i,
      output busy_o, done_o, result_o, rd_addr_o
   );

   modport master (
      output start_i, op_i, rs1_val_i, rs2_val_i, rd_addr_i, flush_i,
      input  busy_o, done_o, result_o, rd_addr_o
   );
endinterface

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation, used for magnitudes and sign fix-up.
module mdu_negate #(
   parameter int unsigned W = 32
) (
   input  logic         neg_i,
   input  logic [W-1:0] val_i,
   output logic [W-1:0] val_o
);
   assign val_o = neg_i ? ('0 - val_i) : val_i;
endmodule

// File: rtl/exe_mdu.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps.
module exe_mdu
   import exe_mdu_pkg::*;
#(
   parameter int unsigned XLEN  = GPR_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic       clk_i,
   input  logic       rst_i,
   exe_mdu_if.slave   bus
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e          state, state_nxt;
   mdu_op_e             op_in, op_q;
   logic [CNT_W-1:0]    cnt;
   logic [XLEN-1:0]     a_sh, mag_b, mag_a_in, mag_b_in;
   logic [2*XLEN-1:0]   acc, mul_next, div_next, prod_fix;
   logic [GPR_ADDR_W-1:0] rd_q;
   logic                sign_a, sign_b, b_zero, ovf;
   logic                sa_in, sb_in, accept;
   logic [XLEN:0]       trial, diff;
   logic                qbit, is_rem;
   logic [XLEN-1:0]     div_raw, div_fix, res_sel;

   assign op_in  = mdu_op_e'(bus.op_i);
   assign sa_in  = op_signed_a(op_in) & bus.rs1_val_i[XLEN-1];
   assign sb_in  = op_signed_b(op_in) & bus.rs2_val_i[XLEN-1];
   assign accept = (state == ST_IDLE) & bus.start_i & ~bus.flush_i;
   assign is_rem = (op_q == OP_REM) | (op_q == OP_REMU);

   mdu_negate #(.W(XLEN)) u_neg_a (.neg_i(sa_in), .val_i(bus.rs1_val_i), .val_o(mag_a_in));
   mdu_negate #(.W(XLEN)) u_neg_b (.neg_i(sb_in), .val_i(bus.rs2_val_i), .val_o(mag_b_in));

   // product is negated as a full 2*XLEN value so the low half stays consistent
   mdu_negate #(.W(2*XLEN)) u_neg_prod (.neg_i(sign_a ^ sign_b), .val_i(acc), .val_o(prod_fix));
   mdu_negate #(.W(XLEN))   u_neg_div  (.neg_i(is_rem ? sign_a : (sign_a ^ sign_b)),
                                        .val_i(div_raw), .val_o(div_fix));

   // one iteration step: MSB-first shift-add, or restoring divide with {rem, quo} in acc
   always_comb begin
      mul_next = {acc[2*XLEN-2:0], 1'b0} + (a_sh[XLEN-1] ? {{XLEN{1'b0}}, mag_b} : '0);
      trial    = {acc[2*XLEN-1:XLEN], a_sh[XLEN-1]};
      diff     = trial - {1'b0, mag_b};
      qbit     = ~diff[XLEN];
      div_next = {(qbit ? diff[XLEN-1:0] : trial[XLEN-1:0]), acc[XLEN-2:0], qbit};
   end

   // state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // next-state logic; flush wins in every state
   always_comb begin
      state_nxt = state;
      if (bus.flush_i) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (bus.start_i) state_nxt = ST_CALC;
            ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // operand capture on accept, one datapath step per CALC cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_q   <= OP_MUL;
         rd_q   <= '0;
         a_sh   <= '0;
         mag_b  <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         b_zero <= 1'b0;
         ovf    <= 1'b0;
         acc    <= '0;
         cnt    <= '0;
      end else if (accept) begin
         op_q   <= op_in;
         rd_q   <= bus.rd_addr_i;
         a_sh   <= mag_a_in;
         mag_b  <= mag_b_in;
         sign_a <= sa_in;
         sign_b <= sb_in;
         b_zero <= (bus.rs2_val_i == '0);
         ovf    <= op_signed_b(op_in) & (bus.rs1_val_i == INT_MIN) & (bus.rs2_val_i == '1);
         acc    <= '0;
         cnt    <= '0;
      end else if ((state == ST_CALC) && !bus.flush_i) begin
         acc    <= op_q[2] ? div_next : mul_next;
         a_sh   <= {a_sh[XLEN-2:0], 1'b0};
         cnt    <= cnt + CNT_W'(1);
      end
   end

   // result selection with divide-by-zero and overflow overrides
   always_comb begin
      div_raw = is_rem ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      case (op_q)
         OP_MUL:                      res_sel = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: res_sel = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:             res_sel = b_zero ? '1 : (ovf ? INT_MIN : div_fix);
         // with b=0 the restoring remainder is |a|, and the sign fix-up turns it back into a
         default:                     res_sel = ovf ? '0 : div_fix;
      endcase
   end

   // FSM outputs; busy is combinational so the issuing cycle is already held
   always_comb begin
      bus.busy_o    = (state == ST_CALC) | accept;
      bus.done_o    = (state == ST_DONE);
      bus.result_o  = (state == ST_DONE) ? res_sel : '0;
      bus.rd_addr_o = rd_q;
   end

endmodule
